// File: rtl/sort_accel_if.sv
// rtl/sort_accel_if.sv - CPU register bus and SDRAM master bus bundle for sort_accel
interface sort_accel_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [2:0]        slave_address;
  logic              slave_read;
  logic [31:0]       slave_readdata;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic              slave_waitrequest;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic [DATA_W-1:0] master_readdata;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic              master_waitrequest;
  logic              irq;

  // Accelerator side: serves the CPU register bus and drives the SDRAM bus.
  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
    output slave_readdata, slave_waitrequest,
    output master_address, master_read, master_write, master_writedata,
    input  master_readdata, master_waitrequest,
    output irq
  );

  // Host/memory side: CPU issuing register accesses plus the SDRAM responder.
  modport master (
    output slave_address, slave_read, slave_write, slave_writedata,
    input  slave_readdata, slave_waitrequest,
    input  master_address, master_read, master_write, master_writedata,
    output master_readdata, master_waitrequest,
    input  irq
  );
endinterface

// File: rtl/sort_accel.sv
// rtl/sort_accel.sv - in-memory bubble sort engine with CPU register slave and SDRAM master
module sort_accel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic              slave_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic              master_waitrequest,
  output logic              irq
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD1   = 3'd1;
  localparam logic [2:0] S_LOAD2   = 3'd2;
  localparam logic [2:0] S_CMP     = 3'd3;
  localparam logic [2:0] S_SWITCH1 = 3'd4;
  localparam logic [2:0] S_SWITCH2 = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_i;
  logic [LEN_W-1:0]  r_limit;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic              r_desc;
  logic              r_signed;
  logic              r_done;
  logic              r_pass_swap;
  logic              r_cur_swap;
  logic [31:0]       r_swaps;
  logic [31:0]       r_passes;
  logic [31:0]       r_readdata;

  logic              w_busy;
  logic              w_ctrl_wr;
  logic              w_start_ok;
  logic [LEN_W-1:0]  w_i_next;
  logic              w_pass_end;
  logic [LEN_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic              w_rd;
  logic              w_wr;
  logic              w_gt;
  logic              w_lt;
  logic              w_swap;
  logic [31:0]       w_rdata;

  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = slave_write && (slave_address == 3'd0);
  assign w_start_ok = w_ctrl_wr && slave_writedata[0] &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));
  // A CTRL write is held off for the whole run and let through in DONE.
  assign slave_waitrequest = w_ctrl_wr && w_busy && (r_state != S_DONE);

  assign w_i_next   = r_i + LEN_W'(1);
  assign w_pass_end = (w_i_next == r_limit);

  assign w_rd = (r_state == S_LOAD1) || (r_state == S_LOAD2);
  assign w_wr = (r_state == S_SWITCH1) || (r_state == S_SWITCH2);

  always_comb begin
    w_idx = '0;
    case (r_state)
      S_LOAD2, S_SWITCH2: w_idx = w_i_next;
      S_SWITCH1:          w_idx = r_i;
      default:            w_idx = '0;
    endcase
  end

  assign w_addr = r_base + (ADDR_W'(w_idx) << SHIFT);

  // Strobes and address derive from state only, so they hold while stalled
  // and drop as soon as reset forces IDLE.
  assign master_address   = (w_rd || w_wr) ? w_addr : '0;
  assign master_read      = w_rd;
  assign master_write     = w_wr;
  assign master_writedata = (r_state == S_SWITCH1) ? r_d2 :
                            (r_state == S_SWITCH2) ? r_d1 : '0;

  assign w_gt   = r_signed ? ($signed(r_d1) > $signed(r_d2)) : (r_d1 > r_d2);
  assign w_lt   = r_signed ? ($signed(r_d1) < $signed(r_d2)) : (r_d1 < r_d2);
  assign w_swap = r_desc ? w_lt : w_gt;

  always_comb begin
    w_rdata = '0;
    case (slave_address)
      3'd1:    w_rdata = 32'(r_base);
      3'd2:    w_rdata = 32'(r_len);
      3'd3:    w_rdata = {30'd0, r_done, w_busy};
      3'd4:    w_rdata = r_swaps;
      3'd5:    w_rdata = r_passes;
      default: w_rdata = '0;
    endcase
  end

  assign slave_readdata = r_readdata;
  assign irq            = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_i         <= '0;
      r_limit     <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_desc      <= 1'b0;
      r_signed    <= 1'b0;
      r_done      <= 1'b0;
      r_pass_swap <= 1'b0;
      r_cur_swap  <= 1'b0;
      r_swaps     <= '0;
      r_passes    <= '0;
      r_readdata  <= '0;
    end else begin
      if (slave_read)
        r_readdata <= w_rdata;
      if (slave_write && (slave_address == 3'd1))
        r_base <= slave_writedata[ADDR_W-1:0];
      if (slave_write && (slave_address == 3'd2))
        r_len <= slave_writedata[LEN_W-1:0];
      if (slave_write && (slave_address == 3'd3) && slave_writedata[1])
        r_done <= 1'b0;

      case (r_state)
        S_LOAD1: begin
          if (!master_waitrequest) begin
            r_d1    <= master_readdata;
            r_state <= S_LOAD2;
          end
        end
        S_LOAD2: begin
          if (!master_waitrequest) begin
            r_d2    <= master_readdata;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_cur_swap <= w_swap;
          if (w_swap) begin
            r_pass_swap <= 1'b1;
            r_state     <= S_SWITCH1;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_SWITCH1: begin
          if (!master_waitrequest)
            r_state <= S_SWITCH2;
        end
        S_SWITCH2: begin
          if (!master_waitrequest) begin
            if (r_swaps != 32'hFFFF_FFFF)
              r_swaps <= r_swaps + 32'd1;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          // a[i+1] now holds the larger-ranked value: d1 after a swap, else d2.
          if (!r_cur_swap)
            r_d1 <= r_d2;
          r_i <= w_i_next;
          if (w_pass_end) begin
            r_passes <= r_passes + 32'd1;
            if (!r_pass_swap || (r_limit == LEN_W'(1))) begin
              r_state <= S_DONE;
            end else begin
              r_limit     <= r_limit - LEN_W'(1);
              r_i         <= '0;
              r_pass_swap <= 1'b0;
              r_state     <= S_LOAD1;
            end
          end else begin
            r_state <= S_LOAD2;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_start_ok) begin
        r_desc      <= slave_writedata[1];
        r_signed    <= slave_writedata[2];
        r_done      <= 1'b0;
        r_swaps     <= '0;
        r_passes    <= '0;
        r_i         <= '0;
        r_limit     <= r_len - LEN_W'(1);
        r_pass_swap <= 1'b0;
        r_cur_swap  <= 1'b0;
        r_state     <= (r_len < LEN_W'(2)) ? S_DONE : S_LOAD1;
      end
    end
  end
endmodule
